// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a valid/ready holding register.
//   clk        system clock, rising edge
//   clr_n      asynchronous active-low reset
//   rx         serial line (idles high, asynchronous to clk)
//   data       received byte from the holding register
//   valid      holding register full
//   ready      consumer accepts data when valid & ready
//   busy       receiver is inside a frame (FSM not IDLE)
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: a completed byte was dropped
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 busy,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW   = $clog2(DATA_BITS + 1);
   localparam int unsigned HALF = CLKS_PER_BIT / 2;

   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [IW-1:0]        idx, idx_nxt;
   logic [DATA_BITS-1:0] shift, shift_nxt;
   logic [DATA_BITS-1:0] data_nxt;
   logic                 valid_nxt;
   logic                 busy_nxt;
   logic                 frame_err_nxt;
   logic                 overrun_nxt;
   logic                 rx_m, rx_s;

   // Two-flop synchronizer; resets to the idle line level.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         idx       <= idx_nxt;
         shift     <= shift_nxt;
         data      <= data_nxt;
         valid     <= valid_nxt;
         busy      <= busy_nxt;
         frame_err <= frame_err_nxt;
         overrun   <= overrun_nxt;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      idx_nxt       = idx;
      shift_nxt     = shift;
      data_nxt      = data;
      valid_nxt     = valid;
      frame_err_nxt = 1'b0;
      overrun_nxt   = 1'b0;

      // Drain; a frame completing on this same edge may re-set valid below.
      if (valid && ready) valid_nxt = 1'b0;

      unique case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nxt = START;
               cnt_nxt   = '0;
            end
         end
         START: begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == CNT_HALF) begin
               cnt_nxt = '0;
               if (!rx_s) begin
                  state_nxt = DATA;
                  idx_nxt   = '0;
               end else begin
                  state_nxt = IDLE;   // glitch, not a real start bit
               end
            end
         end
         DATA: begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == CNT_LAST) begin
               // LSB first: after DATA_BITS shifts bit 0 sits at position 0.
               shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
               cnt_nxt   = '0;
               idx_nxt   = idx + IW'(1);
               if (idx == IDX_LAST) state_nxt = STOP;
            end
         end
         STOP: begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               if (rx_s) begin
                  if (!valid || ready) begin
                     data_nxt  = shift;
                     valid_nxt = 1'b1;
                  end else begin
                     overrun_nxt = 1'b1;
                  end
               end else begin
                  frame_err_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the data logger's input side. It oversamples a UART line, assembles each LSB-first frame into a byte and presents it on a valid/ready holding register. It sits directly upstream of the logger's byte-wide storage and shift registers. It also reports framing errors and overruns as single-cycle pulses.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit (C). Must be ≥ 4. H = C/2, using integer division.
- DATA_BITS, default 8: data bits per frame. Range 5–8.
- clk  input  1  system clock; all logic is on its rising edge.
- clr_n  input  1  reset, asynchronous assert, active-low.
- rx  input  1  serial line; idles high; asynchronous to clk.
- data  output  DATA_BITS  received byte from the holding register.
- valid  output  1  holding register is full.
- ready  input  1  consumer accepts data when valid & ready.
- busy  output  1  high whenever the FSM is not IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a completed byte was dropped.

## Operation
- Input synchronizer: rx passes through a 2-flop synchronizer. Its output is rx_s.
  - The synchronizer flops reset to 1.
  - The FSM sees only rx_s.
- Counters:
  - bit-time counter cnt, width $clog2(C).
  - bit index idx, width $clog2(DATA_BITS+1).
- IDLE:
  - If rx_s == 0: go to START, cnt <= 0.
- START:
  - cnt increments each cycle.
  - At cnt == H-1, sample rx_s.
    - If 0: go to DATA, cnt <= 0, idx <= 0.
    - If 1: treat as a glitch and return to IDLE. No flags are raised.
- DATA:
  - cnt increments each cycle.
  - At cnt == C-1: sample rx_s into shift[idx] (LSB first), cnt <= 0, idx++.
  - After the DATA_BITS-th sample: go to STOP.
- STOP:
  - At cnt == C-1, sample rx_s and return to IDLE. Do not wait for the end of the stop bit.
  - If the sample is 1, the frame is good:
    - If the holding register is free, or is being drained this cycle (valid & ready), load data <= shift and set valid <= 1.
    - Otherwise the new byte is discarded, data keeps the old byte, and overrun pulses.
  - If the sample is 0: frame_err pulses, the byte is discarded, and valid/data are unchanged.
- Handshake:
  - valid clears on the cycle after valid & ready, unless a good frame completes on that same edge. In that case valid stays 1 and data takes the new byte.
  - data is stable while valid=1 and no transfer occurs.
  - ready is ignored when valid=0.
- Reset (clr_n=0), including mid-frame:
  - Returns to IDLE immediately.
  - The partial frame is discarded and no flags are raised.

## Timing
- Reset values:
  - data = 0, valid = 0, busy = 0, frame_err = 0, overrun = 0.
  - state = IDLE, cnt = 0, idx = 0.
- Reference point: edge 0 is the first clk edge at which the FSM sees rx_s == 0 in IDLE. rx_s lags rx by 2 cycles.
- busy is 1 from after edge 0 until after the stop-sample edge.
- Sample edges:
  - start bit: edge H.
  - data bit i: edge H + (i+1)·C.
  - stop bit: edge H + (DATA_BITS+1)·C.
- valid, frame_err and overrun update on the stop-sample edge.
  - For defaults (C=16, 8 bits) this is edge 152.
- Back-to-back frames: a start bit arriving immediately after the stop bit is detected. The FSM is in IDLE for the last H cycles of the stop bit.
- Throughput: one byte per (DATA_BITS+2)·C cycles maximum.

## Test plan
- Reset, then send 0xA5 at C=16, 8N1, with ready=0.
  - Required: valid rises after edge 152 and data=0xA5.
  - Required: busy falls on the same edge, and no flags are raised.
- Send 0x3C then 0xC3 back-to-back with ready=0 throughout.
  - Required: data stays 0x3C and valid stays 1.
  - Required: overrun pulses exactly 1 cycle at the second stop-sample edge.
- Hold valid=1 with 0x11, then complete 0x22 on the exact edge where ready=1.
  - Required: valid stays 1, data=0x22, no overrun.
- Pull rx low for 4 cycles, then high.
  - Required: START aborts at edge 8, state returns to IDLE, and busy=0 afterwards.
  - Required: valid, frame_err and overrun stay 0.
- Send 0x55 with the stop bit driven 0.
  - Required: frame_err pulses 1 cycle at edge 152, valid stays 0, data unchanged.
- Assert clr_n=0 mid-DATA (after bit 3), release, then send 0x81.
  - Required: outputs are at their reset values during reset.
  - Required: only 0x81 is delivered, with valid after the standard 152-edge latency.
